// File: rtl/qspi_flash_writer_shift_pkg.sv
// Shared definitions for the QSPI flash writer: register map, write-enable key,
// engine state encoding and lane-drive helpers.
package qspi_flash_writer_shift_pkg;

  localparam logic [7:0] REG_WE     = 8'h00;
  localparam logic [7:0] REG_CTRL   = 8'h04;
  localparam logic [7:0] REG_TX     = 8'h08;
  localparam logic [7:0] REG_RX     = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h10;
  localparam logic [7:0] REG_ID     = 8'h14;

  localparam logic [23:0] WE_KEY = 24'hA5A855;

  localparam int unsigned CTRL_SS      = 0;
  localparam int unsigned CTRL_QUAD    = 1;
  localparam int unsigned CTRL_QRD     = 2;
  localparam int unsigned CTRL_DIV_LSB = 8;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_HOLD = 1;
  localparam int unsigned ST_OVF  = 2;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_LO,
    ENG_HI
  } eng_state_t;

  // Data presented on the lanes for the MSB end of the shift register.
  function automatic logic [3:0] lane_data(input logic [7:0] sh, input logic quad);
    return quad ? sh[7:4] : {3'b000, sh[7]};
  endfunction

  function automatic logic [3:0] lane_oe(input logic quad, input logic qrd);
    if (!quad) return 4'b0001;
    return qrd ? 4'b0000 : 4'b1111;
  endfunction

endpackage

// File: rtl/qspi_shift_engine.sv
// SPI mode-0 byte shifter with programmable SCK divider, single/quad lanes and a
// one-deep TX holding buffer for back-to-back bytes.
module qspi_shift_engine
  import qspi_flash_writer_shift_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             push,
  input  logic [7:0]       push_byte,
  input  logic             quad,
  input  logic             qrd,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       din,
  output logic             sck,
  output logic [3:0]       dout,
  output logic [3:0]       oe,
  output logic [7:0]       rx,
  output logic             busy,
  output logic             hold_full,
  output logic             drop
);

  eng_state_t       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cur_div;
  logic [2:0]       bits_left;
  logic             cur_quad;
  logic [7:0]       tx_sh;
  logic [7:0]       tx_next;
  logic [7:0]       rx_sh;
  logic [7:0]       hold;
  logic             cnt_zero;
  logic             last_edge;
  logic             load_now;
  logic [7:0]       load_byte;

  assign cnt_zero  = (cnt == '0);
  assign last_edge = (state == ENG_HI) && cnt_zero && (bits_left == '0);
  assign tx_next   = cur_quad ? {tx_sh[3:0], 4'b0000} : {tx_sh[6:0], 1'b0};
  assign busy      = (state != ENG_IDLE) || hold_full;
  // A push landing on the final HI cycle is never dropped: the hold slot frees that edge.
  assign drop      = push && !abort && (state != ENG_IDLE) && hold_full && !last_edge;

  always_comb begin
    load_now  = 1'b0;
    load_byte = push_byte;
    if (state == ENG_IDLE) begin
      load_now = push;
    end else if (last_edge) begin
      load_now  = hold_full || push;
      load_byte = hold_full ? hold : push_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ENG_IDLE;
      cnt       <= '0;
      cur_div   <= '0;
      bits_left <= '0;
      cur_quad  <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      rx        <= '0;
      sck       <= 1'b0;
      dout      <= '0;
      oe        <= '0;
    end else if (abort) begin
      state     <= ENG_IDLE;
      hold_full <= 1'b0;
      sck       <= 1'b0;
      dout      <= '0;
      oe        <= '0;
    end else begin
      if (last_edge) begin
        hold_full <= hold_full & push;
        if (hold_full && push) hold <= push_byte;
        rx <= rx_sh;
      end else if ((state != ENG_IDLE) && push && !hold_full) begin
        hold      <= push_byte;
        hold_full <= 1'b1;
      end

      if (load_now) begin
        state     <= ENG_LO;
        cnt       <= div;
        cur_div   <= div;
        cur_quad  <= quad;
        bits_left <= quad ? 3'd1 : 3'd7;
        tx_sh     <= load_byte;
        sck       <= 1'b0;
        dout      <= lane_data(load_byte, quad);
        oe        <= lane_oe(quad, qrd);
      end else begin
        case (state)
          ENG_LO: begin
            if (cnt_zero) begin
              rx_sh <= cur_quad ? {rx_sh[3:0], din} : {rx_sh[6:0], din[1]};
              cnt   <= cur_div;
              state <= ENG_HI;
              sck   <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ENG_HI: begin
            if (cnt_zero) begin
              if (bits_left != '0) begin
                bits_left <= bits_left - 3'd1;
                tx_sh     <= tx_next;
                dout      <= lane_data(tx_next, cur_quad);
                cnt       <= cur_div;
                state     <= ENG_LO;
                sck       <= 1'b0;
              end else begin
                state <= ENG_IDLE;
                sck   <= 1'b0;
                dout  <= '0;
                oe    <= '0;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/qspi_flash_writer_shift.sv
// AHB-Lite register front end and flash pin mux: the flash reader owns the pads
// unless the keyed write-enable hands them to the byte shift engine.
module qspi_flash_writer_shift
  import qspi_flash_writer_shift_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned RST_DIV = 3,
  parameter logic [31:0] ID_VAL  = 32'hABCD0002
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        fr_sck,
  input  logic        fr_ce_n,
  input  logic [3:0]  fr_dout,
  input  logic        fr_douten,
  output logic [3:0]  fr_din,
  output logic        fm_sck,
  output logic        fm_ce_n,
  input  logic [3:0]  fm_din,
  output logic [3:0]  fm_dout,
  output logic [3:0]  fm_douten
);

  logic             a_valid;
  logic             a_write;
  logic [7:0]       a_addr;
  logic             wr;
  logic             we;
  logic             ss;
  logic             quad;
  logic             qrd;
  logic [DIV_W-1:0] div;
  logic             ovf;
  logic             we_key_wr;
  logic             abort;
  logic             push;
  logic             eng_sck;
  logic [3:0]       eng_dout;
  logic [3:0]       eng_oe;
  logic [7:0]       eng_rx;
  logic             eng_busy;
  logic             eng_hold_full;
  logic             eng_drop;
  logic [31:0]      ctrl_rd;
  logic             unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:8], HTRANS[0]};
  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
    end else if (HREADY) begin
      a_valid <= HSEL & HTRANS[1];
      if (HSEL && HTRANS[1]) begin
        a_write <= HWRITE;
        a_addr  <= HADDR[7:0];
      end
    end
  end

  assign wr        = a_valid & a_write;
  assign we_key_wr = wr && (a_addr == REG_WE) && (HWDATA[31:8] == WE_KEY);
  // Abort on the same edge that clears WE so the engine never runs unowned.
  assign abort     = !we || (we_key_wr && !HWDATA[0]);
  assign push      = wr && (a_addr == REG_TX) && we;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      we   <= 1'b0;
      ss   <= 1'b1;
      quad <= 1'b0;
      qrd  <= 1'b0;
      div  <= DIV_W'(RST_DIV);
      ovf  <= 1'b0;
    end else begin
      if (we_key_wr) we <= HWDATA[0];
      if (wr && (a_addr == REG_CTRL)) begin
        ss   <= HWDATA[CTRL_SS];
        quad <= HWDATA[CTRL_QUAD];
        qrd  <= HWDATA[CTRL_QRD];
        div  <= HWDATA[CTRL_DIV_LSB +: DIV_W];
      end
      if (eng_drop) begin
        ovf <= 1'b1;
      end else if (wr && (a_addr == REG_STATUS) && HWDATA[ST_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

  qspi_shift_engine #(.DIV_W(DIV_W)) u_engine (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .abort     (abort),
    .push      (push),
    .push_byte (HWDATA[7:0]),
    .quad      (quad),
    .qrd       (qrd),
    .div       (div),
    .din       (fm_din),
    .sck       (eng_sck),
    .dout      (eng_dout),
    .oe        (eng_oe),
    .rx        (eng_rx),
    .busy      (eng_busy),
    .hold_full (eng_hold_full),
    .drop      (eng_drop)
  );

  always_comb begin
    ctrl_rd                         = '0;
    ctrl_rd[CTRL_SS]                = ss;
    ctrl_rd[CTRL_QUAD]              = quad;
    ctrl_rd[CTRL_QRD]               = qrd;
    ctrl_rd[CTRL_DIV_LSB +: DIV_W]  = div;
  end

  always_comb begin
    HRDATA = '0;
    if (a_valid) begin
      case (a_addr)
        REG_WE:     HRDATA = {31'b0, we};
        REG_CTRL:   HRDATA = ctrl_rd;
        REG_RX:     HRDATA = {24'b0, eng_rx};
        REG_STATUS: HRDATA = {29'b0, ovf, eng_hold_full, eng_busy};
        REG_ID:     HRDATA = ID_VAL;
        default:    HRDATA = '0;
      endcase
    end
  end

  assign fr_din    = fm_din;
  assign fm_sck    = we ? eng_sck  : fr_sck;
  assign fm_ce_n   = we ? ss       : fr_ce_n;
  assign fm_dout   = we ? eng_dout : fr_dout;
  assign fm_douten = we ? eng_oe   : {4{fr_douten}};

endmodule

// File: tb/tb_qspi_flash_writer_shift.sv
// Scoreboarded bench for qspi_flash_writer_shift: register reads and per-SCK lane
// values are queued as expectations and compared as the DUT produces them.
module tb_qspi_flash_writer_shift;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        fr_sck;
  logic        fr_ce_n;
  logic [3:0]  fr_dout;
  logic        fr_douten;
  logic [3:0]  fr_din;
  logic        fm_sck;
  logic        fm_ce_n;
  logic [3:0]  fm_din;
  logic [3:0]  fm_dout;
  logic [3:0]  fm_douten;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  obs_q[$];
  int          stamp_q[$];

  // Flash response model: shifts one bit (or nibble) per falling SCK edge.
  logic        tb_quad = 1'b0;
  logic [31:0] resp = '0;
  int unsigned nshift = 0;
  int unsigned base = 0;
  int unsigned shamt;
  logic [31:0] cur_resp;

  always #5 HCLK = ~HCLK;
  always @(negedge fm_sck) nshift <= nshift + 1;

  assign shamt    = tb_quad ? 4 * (nshift - base) : (nshift - base);
  assign cur_resp = resp << shamt;
  assign fm_din   = tb_quad ? cur_resp[31:28] : {2'b00, cur_resp[31], 1'b0};

  qspi_flash_writer_shift #(.DIV_W(8), .RST_DIV(3), .ID_VAL(32'hABCD0002)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HSIZE     (HSIZE),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .fr_sck    (fr_sck),
    .fr_ce_n   (fr_ce_n),
    .fr_dout   (fr_dout),
    .fr_douten (fr_douten),
    .fr_din    (fr_din),
    .fm_sck    (fm_sck),
    .fm_ce_n   (fm_ce_n),
    .fm_din    (fm_din),
    .fm_dout   (fm_dout),
    .fm_douten (fm_douten)
  );

  task automatic ahb_write(input logic [7:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, addr};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [7:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, addr};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  // Records {oe, dout} and the cycle index at each rising SCK, sampled on negedge HCLK.
  task automatic capture_edges(input int n, input int budget);
    logic prev;
    int   cyc;
    int   seen;
    prev = fm_sck; cyc = 0; seen = 0;
    while (seen < n && cyc < budget) begin
      @(negedge HCLK);
      cyc++;
      if (fm_sck && !prev) begin
        obs_q.push_back({fm_douten, fm_dout});
        stamp_q.push_back(cyc);
        seen++;
      end
      prev = fm_sck;
    end
  endtask

  task automatic test_reset();
    logic [7:0]  addrs[6] = '{8'h14, 8'h04, 8'h10, 8'h00, 8'h0C, 8'h18};
    logic [31:0] vals[6]  = '{32'hABCD0002, 32'h0000_0301, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] got, e;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HREADY = 1'b1; HWDATA = '0; HSIZE = 3'b010;
    fr_sck = 1'b0; fr_ce_n = 1'b1; fr_dout = 4'h0; fr_douten = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    for (int i = 0; i < 6; i++) exp_q.push_back(vals[i]);
    for (int i = 0; i < 6; i++) begin
      ahb_read(addrs[i], got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL reset_reg_%h: got %h expected %h", addrs[i], got, e); end
    end
    for (int i = 0; i < 3; i++) begin
      fr_ce_n = i[0]; #1;
      n_checks++;
      if (fm_ce_n !== fr_ce_n) begin n_fail++; $display("FAIL ce_passthru: got %b expected %b", fm_ce_n, fr_ce_n); end
    end
    n_checks++;
    if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL hreadyout: got %b expected 1", HREADYOUT); end
    n_checks++;
    if (fr_din !== fm_din) begin n_fail++; $display("FAIL fr_din: got %h expected %h", fr_din, fm_din); end
  endtask

  task automatic test_we();
    logic [31:0] got, e;
    fr_sck = 1'b1; fr_ce_n = 1'b0;
    ahb_write(8'h00, 32'h12345601);
    exp_q.push_back(32'h0);
    ahb_read(8'h00, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL we_bad_key: got %h expected %h", got, e); end
    n_checks++;
    if (fm_sck !== 1'b1) begin n_fail++; $display("FAIL sck_passthru: got %b expected 1", fm_sck); end
    ahb_write(8'h00, 32'hA5A85501);
    exp_q.push_back(32'h1);
    ahb_read(8'h00, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL we_good_key: got %h expected %h", got, e); end
    n_checks++;
    if ({fm_ce_n, fm_sck, fm_douten} !== 6'b10_0000) begin
      n_fail++; $display("FAIL we_pins: got ce=%b sck=%b oe=%b expected ce=1 sck=0 oe=0000", fm_ce_n, fm_sck, fm_douten);
    end
  endtask

  task automatic test_single();
    logic [7:0]  tx = 8'h9F;
    logic [31:0] got, e;
    logic [7:0]  o;
    int          t, exp_t;
    ahb_write(8'h04, 32'h0000_0000);
    n_checks++;
    if (fm_ce_n !== 1'b0) begin n_fail++; $display("FAIL ss_low: got %b expected 0", fm_ce_n); end
    tb_quad = 1'b0; resp = 32'hC200_0000; base = nshift;
    for (int i = 7; i >= 0; i--) exp_q.push_back({24'h0, 4'b0001, 3'b000, tx[i]});
    ahb_write(8'h08, {24'h0, tx});
    capture_edges(8, 40);
    n_checks++;
    if (obs_q.size() != 8) begin n_fail++; $display("FAIL single_edges: got %0d expected 8", obs_q.size()); end
    exp_t = 2;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = stamp_q.pop_front();
      n_checks++;
      if (o !== e[7:0]) begin n_fail++; $display("FAIL single_lane: got %h expected %h", o, e[7:0]); end
      n_checks++;
      if (t != exp_t) begin n_fail++; $display("FAIL single_timing: got cycle %0d expected %0d", t, exp_t); end
      exp_t += 2;
    end
    exp_q.delete(); obs_q.delete(); stamp_q.delete();
    @(posedge HCLK); #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hC2);
    ahb_read(8'h10, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL single_status: got %h expected %h", got, e); end
    ahb_read(8'h0C, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL single_rx: got %h expected %h", got, e); end
  endtask

  task automatic test_quad_back_to_back();
    logic [31:0] s1, s2, e;
    logic [7:0]  o;
    int          t, exp_t;
    ahb_write(8'h04, 32'h0000_0102);
    tb_quad = 1'b1; resp = 32'h0; base = nshift;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back({24'h0, 8'hFA}); exp_q.push_back({24'h0, 8'hF5});
    exp_q.push_back({24'h0, 8'hF3}); exp_q.push_back({24'h0, 8'hFC});
    ahb_write(8'h08, 32'hA5);
    fork
      capture_edges(4, 60);
      begin
        ahb_write(8'h08, 32'h3C);
        ahb_read(8'h10, s1);
        repeat (6) @(posedge HCLK);
        #1;
        ahb_read(8'h10, s2);
      end
    join
    n_checks++;
    if (obs_q.size() != 4) begin n_fail++; $display("FAIL quad_edges: got %0d expected 4", obs_q.size()); end
    exp_t = 3;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = stamp_q.pop_front();
      n_checks++;
      if (o !== e[7:0]) begin n_fail++; $display("FAIL quad_lane: got %h expected %h", o, e[7:0]); end
      n_checks++;
      if (t != exp_t) begin n_fail++; $display("FAIL quad_timing: got cycle %0d expected %0d", t, exp_t); end
      exp_t += 4;
    end
    exp_q.delete(); obs_q.delete(); stamp_q.delete();
    n_checks++;
    if (s1 !== 32'h3) begin n_fail++; $display("FAIL quad_hold_full: got %h expected 00000003", s1); end
    n_checks++;
    if (s2 !== 32'h1) begin n_fail++; $display("FAIL quad_hold_pop: got %h expected 00000001", s2); end
    repeat (3) @(posedge HCLK);
    #1;
  endtask

  task automatic test_push_on_pop();
    logic [31:0] s1, got, e;
    logic [7:0]  o;
    int          t, exp_t;
    ahb_write(8'h04, 32'h0000_0002);
    for (int i = 1; i <= 6; i++) exp_q.push_back({24'h0, 4'hF, i[3:0]});
    ahb_write(8'h08, 32'h12);
    fork
      capture_edges(6, 40);
      begin
        ahb_write(8'h08, 32'h34);
        ahb_write(8'h08, 32'h56);
        ahb_read(8'h10, s1);
      end
    join
    n_checks++;
    if (obs_q.size() != 6) begin n_fail++; $display("FAIL pop_edges: got %0d expected 6", obs_q.size()); end
    exp_t = 2;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = stamp_q.pop_front();
      n_checks++;
      if (o !== e[7:0]) begin n_fail++; $display("FAIL pop_lane: got %h expected %h", o, e[7:0]); end
      n_checks++;
      if (t != exp_t) begin n_fail++; $display("FAIL pop_timing: got cycle %0d expected %0d", t, exp_t); end
      exp_t += 2;
    end
    exp_q.delete(); obs_q.delete(); stamp_q.delete();
    n_checks++;
    if (s1 !== 32'h3) begin n_fail++; $display("FAIL pop_accept: got %h expected 00000003", s1); end
    @(posedge HCLK); #1;
    exp_q.push_back(32'h0);
    ahb_read(8'h10, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL pop_no_ovf: got %h expected %h", got, e); end
  endtask

  task automatic test_overflow();
    logic [31:0] got, e;
    ahb_write(8'h04, 32'h0000_0102);
    exp_q.push_back(32'h7);
    exp_q.push_back(32'h1);
    ahb_write(8'h08, 32'h11);
    ahb_write(8'h08, 32'h22);
    ahb_write(8'h08, 32'h33);
    ahb_read(8'h10, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL ovf_set: got %h expected %h", got, e); end
    ahb_write(8'h10, 32'h4);
    ahb_read(8'h10, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL ovf_clear: got %h expected %h", got, e); end
    repeat (20) @(posedge HCLK);
    #1;
  endtask

  task automatic test_quad_read();
    logic [31:0] got, e;
    logic [7:0]  o;
    int          t, exp_t;
    ahb_write(8'h04, 32'h0000_0106);
    tb_quad = 1'b1; resp = 32'h7E00_0000; base = nshift;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    ahb_write(8'h08, 32'h00);
    capture_edges(2, 20);
    n_checks++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL qrd_edges: got %0d expected 2", obs_q.size()); end
    exp_t = 3;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = stamp_q.pop_front();
      n_checks++;
      if (o !== e[7:0]) begin n_fail++; $display("FAIL qrd_lane: got %h expected %h", o, e[7:0]); end
      n_checks++;
      if (t != exp_t) begin n_fail++; $display("FAIL qrd_timing: got cycle %0d expected %0d", t, exp_t); end
      exp_t += 4;
    end
    exp_q.delete(); obs_q.delete(); stamp_q.delete();
    repeat (2) @(posedge HCLK);
    #1;
    exp_q.push_back(32'h7E);
    ahb_read(8'h0C, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL qrd_rx: got %h expected %h", got, e); end
  endtask

  task automatic test_abort();
    logic [31:0] got, e;
    fr_sck = 1'b1; fr_ce_n = 1'b0; fr_dout = 4'hA; fr_douten = 1'b1;
    ahb_write(8'h08, 32'h11);
    ahb_write(8'h08, 32'h22);
    ahb_write(8'h08, 32'h33);
    ahb_write(8'h00, 32'hA5A85500);
    n_checks++;
    if ({fm_sck, fm_ce_n, fm_dout, fm_douten} !== {1'b1, 1'b0, 4'hA, 4'hF}) begin
      n_fail++;
      $display("FAIL abort_pins: got sck=%b ce=%b dout=%h oe=%h expected sck=1 ce=0 dout=a oe=f",
               fm_sck, fm_ce_n, fm_dout, fm_douten);
    end
    ahb_write(8'h08, 32'h44);
    ahb_write(8'h00, 32'hA5A85501);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h7E);
    ahb_read(8'h10, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL abort_status: got %h expected %h", got, e); end
    ahb_read(8'h0C, got); e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL abort_rx: got %h expected %h", got, e); end
    n_checks++;
    if ({fm_sck, fm_ce_n, fm_douten} !== 6'b00_0000) begin
      n_fail++; $display("FAIL abort_idle_pins: got sck=%b ce=%b oe=%h expected sck=0 ce=0 oe=0", fm_sck, fm_ce_n, fm_douten);
    end
    ahb_write(8'h10, 32'h4);
  endtask

  task automatic test_async_reset();
    logic [7:0]  addrs[4] = '{8'h04, 8'h00, 8'h10, 8'h0C};
    logic [31:0] vals[4]  = '{32'h0000_0301, 32'h0, 32'h0, 32'h0};
    logic [31:0] got, e;
    fr_ce_n = 1'b1; fr_sck = 1'b0; fr_douten = 1'b0;
    ahb_write(8'h04, 32'h0000_0000);
    ahb_write(8'h08, 32'h55);
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    n_checks++;
    if ({fm_ce_n, fm_sck, fm_douten} !== 6'b10_0000) begin
      n_fail++; $display("FAIL rst_pins: got ce=%b sck=%b oe=%h expected ce=1 sck=0 oe=0", fm_ce_n, fm_sck, fm_douten);
    end
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
    for (int i = 0; i < 4; i++) begin
      ahb_read(addrs[i], got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL rst_reg_%h: got %h expected %h", addrs[i], got, e); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_we();
    test_single();
    test_quad_back_to_back();
    test_push_on_pop();
    test_overflow();
    test_quad_read();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
